// File: rtl/vga_pkg.sv
// Shared 640x480@60 timing constants and DAC control types for the video pipeline.
package vga_pkg;

    localparam int VGA_CW   = 10;

    localparam int H_ACTIVE = 640;
    localparam int H_FP     = 16;
    localparam int H_SYNC   = 96;
    localparam int H_BP     = 48;
    localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;

    localparam int V_ACTIVE = 480;
    localparam int V_FP     = 10;
    localparam int V_SYNC   = 2;
    localparam int V_BP     = 33;
    localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;

    typedef logic [VGA_CW-1:0] coord_t;

    // Field order is the bit order carried through the DAC delay line.
    typedef struct packed {
        logic hs_n;
        logic vs_n;
        logic blank_n;
    } dac_ctrl_t;

    localparam dac_ctrl_t DAC_IDLE = '{hs_n: 1'b1, vs_n: 1'b1, blank_n: 1'b0};

    function automatic logic in_window(input coord_t pos, input coord_t lo, input coord_t hi);
        return (pos >= lo) && (pos < hi);
    endfunction

endpackage

// File: rtl/vga_timing_delay_line.sv
// Clock-enabled shift register with synchronous reset of every stage to a fixed value.
module delay_line
#(
    parameter int               WIDTH     = 3,
    parameter int               DEPTH     = 1,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
)
(
    input  logic             clk,
    input  logic             reset,
    input  logic             ce_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] stage_q [DEPTH];

    // NOTE: every stage is reset, not just the last, so no stale sync pulse can leak out after reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                stage_q[i] <= RESET_VAL;
            end
        end else if (ce_i) begin
            // NOTE: non-blocking assignments make each stage take its neighbour's old value.
            stage_q[0] <= d_i;
            for (int i = 1; i < DEPTH; i++) begin
                stage_q[i] <= stage_q[i-1];
            end
        end
    end

    assign q_o = stage_q[DEPTH-1];

endmodule

// File: rtl/vga_timing.sv
// Raster counters, active/vblank decode and PIPE_DLY-aligned VGA DAC control signals.
module vga_timing
    import vga_pkg::*;
#(
    parameter int H_ACTIVE = vga_pkg::H_ACTIVE,
    parameter int H_FP     = vga_pkg::H_FP,
    parameter int H_SYNC   = vga_pkg::H_SYNC,
    parameter int H_BP     = vga_pkg::H_BP,
    parameter int V_ACTIVE = vga_pkg::V_ACTIVE,
    parameter int V_FP     = vga_pkg::V_FP,
    parameter int V_SYNC   = vga_pkg::V_SYNC,
    parameter int V_BP     = vga_pkg::V_BP,
    parameter int PIPE_DLY = 1
)
(
    input  logic              clk,
    input  logic              reset,
    input  logic              ce,
    output logic [VGA_CW-1:0] x,
    output logic [VGA_CW-1:0] y,
    output logic              active,
    output logic              vblank,
    output logic              frame_start,
    output logic              vga_hs,
    output logic              vga_vs,
    output logic              vga_blank,
    output logic              vga_sync
);

    localparam int LINE_LEN    = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int FRAME_LINES = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam coord_t X_LAST     = coord_t'(LINE_LEN - 1);
    localparam coord_t Y_LAST     = coord_t'(FRAME_LINES - 1);
    localparam coord_t X_ACT_END  = coord_t'(H_ACTIVE);
    localparam coord_t Y_ACT_END  = coord_t'(V_ACTIVE);
    localparam coord_t HS_START   = coord_t'(H_ACTIVE + H_FP);
    localparam coord_t HS_END     = coord_t'(H_ACTIVE + H_FP + H_SYNC);
    localparam coord_t VS_START   = coord_t'(V_ACTIVE + V_FP);
    localparam coord_t VS_END     = coord_t'(V_ACTIVE + V_FP + V_SYNC);

    coord_t    x_q, x_d;
    coord_t    y_q, y_d;
    dac_ctrl_t dac_raw;
    dac_ctrl_t dac_dly;

    // NOTE: next-state defaults to the current state so no path infers a latch.
    always_comb begin
        x_d = x_q;
        y_d = y_q;
        if (ce) begin
            if (x_q == X_LAST) begin
                x_d = '0;
                y_d = (y_q == Y_LAST) ? '0 : y_q + 1'b1;
            end else begin
                x_d = x_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            x_q <= '0;
            y_q <= '0;
        end else begin
            x_q <= x_d;
            y_q <= y_d;
        end
    end

    always_comb begin
        dac_raw.hs_n    = !in_window(x_q, HS_START, HS_END);
        dac_raw.vs_n    = !in_window(y_q, VS_START, VS_END);
        dac_raw.blank_n = active;
    end

    // Delay matches the mixer's registered palette output so sync and pixels stay aligned.
    delay_line #(
        .WIDTH     ($bits(dac_ctrl_t)),
        .DEPTH     (PIPE_DLY),
        .RESET_VAL (DAC_IDLE)
    ) u_dac_dly (
        .clk   (clk),
        .reset (reset),
        .ce_i  (ce),
        .d_i   (dac_raw),
        .q_o   (dac_dly)
    );

    assign x           = x_q;
    assign y           = y_q;
    assign active      = (x_q < X_ACT_END) && (y_q < Y_ACT_END);
    assign vblank      = (y_q >= Y_ACT_END);
    assign frame_start = ce && (x_q == '0) && (y_q == '0);
    assign vga_hs      = dac_dly.hs_n;
    assign vga_vs      = dac_dly.vs_n;
    assign vga_blank   = dac_dly.blank_n;
    assign vga_sync    = 1'b0;

endmodule

// File: tb/tb_vga_timing.sv
// Directed bench: default-timing instance for line/reset behaviour, tiny-timing PIPE_DLY=3 instance for frames.
module tb_vga_timing;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset_a, ce_a, reset_b, ce_b;
    logic [9:0] x_a, y_a, x_b, y_b;
    logic       active_a, vblank_a, fs_a, hs_a, vs_a, blank_a, sync_a;
    logic       active_b, vblank_b, fs_b, hs_b, vs_b, blank_b, sync_b;

    vga_timing dut_a (
        .clk(clk), .reset(reset_a), .ce(ce_a), .x(x_a), .y(y_a),
        .active(active_a), .vblank(vblank_a), .frame_start(fs_a),
        .vga_hs(hs_a), .vga_vs(vs_a), .vga_blank(blank_a), .vga_sync(sync_a)
    );

    // 15 x 8 raster: 120 cycles per frame
    vga_timing #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
        .PIPE_DLY(3)
    ) dut_b (
        .clk(clk), .reset(reset_b), .ce(ce_b), .x(x_b), .y(y_b),
        .active(active_b), .vblank(vblank_b), .frame_start(fs_b),
        .vga_hs(hs_b), .vga_vs(vs_b), .vga_blank(blank_b), .vga_sync(sync_b)
    );

    int passed = 0;
    int total  = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total = total + 1;
        assert (obs === exp) passed = passed + 1;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference raster for the small instance: {hs_n, vs_n, blank_n} at ce-cycle c.
    function automatic logic [2:0] small_raw(input int c);
        int xm, ym;
        xm = c % 15;
        ym = (c / 15) % 8;
        return {!(xm >= 10 && xm < 13), !(ym >= 5 && ym < 7), (xm < 8 && ym < 4)};
    endfunction

    int hs_low, blank_hi, first_hs, last_hs, max_x, max_y, fs_extra;
    int stable_err, seek_ok, err_xy, err_comb, err_hs, err_vs, err_blank;
    int fs_cnt, vs_win, vb_frame;
    logic [23:0] snap;

    initial begin
        reset_a = 1'b1; ce_a = 1'b1;
        reset_b = 1'b1; ce_b = 1'b1;
        repeat (3) tick();

        check("rst_x", x_a, 0);
        check("rst_y", y_a, 0);
        check("rst_hs", hs_a, 1);
        check("rst_vs", vs_a, 1);
        check("rst_blank", blank_a, 0);
        check("rst_sync", sync_a, 0);

        reset_a = 1'b0;
        #1;
        check("start_fs", fs_a, 1);
        check("start_active", active_a, 1);
        check("start_vblank", vblank_a, 0);

        // One full line at ce=1
        hs_low = 0; blank_hi = 0; first_hs = -1; last_hs = -1; max_x = 0; fs_extra = 0;
        for (int i = 0; i < 800; i++) begin
            if (int'(x_a) > max_x) max_x = int'(x_a);
            if (!hs_a) begin
                if (first_hs < 0) first_hs = int'(x_a);
                last_hs = int'(x_a);
                hs_low++;
            end
            if (blank_a) blank_hi++;
            if (i > 0 && fs_a) fs_extra++;
            tick();
        end
        check("line_hs_low", hs_low, 96);
        check("line_hs_first_x", first_hs, 657);
        check("line_hs_last_x", last_hs, 752);
        check("line_blank_hi", blank_hi, 640);
        check("line_max_x", max_x, 799);
        check("line_wrap_x", x_a, 0);
        check("line_wrap_y", y_a, 1);
        check("line_fs_extra", fs_extra, 0);

        // ce toggling: one line takes 1600 cycles, ce=0 cycles change nothing
        stable_err = 0;
        for (int i = 0; i < 1600; i++) begin
            ce_a = (i % 2 == 0);
            #1;
            if (fs_a) stable_err++;
            snap = {x_a, y_a, hs_a, vs_a, blank_a, active_a};
            tick();
            if (!ce_a && snap !== {x_a, y_a, hs_a, vs_a, blank_a, active_a}) stable_err++;
        end
        check("cetog_stable", stable_err, 0);
        check("cetog_x", x_a, 0);
        check("cetog_y", y_a, 2);

        // Seek x=300,y=2 and reset mid-frame
        ce_a = 1'b1;
        seek_ok = 0;
        for (int i = 0; i < 1000; i++) begin
            if (x_a == 10'd300 && y_a == 10'd2) begin
                seek_ok = 1;
                break;
            end
            tick();
        end
        check("seek_reached", seek_ok, 1);
        check("pre_rst_blank", blank_a, 1);
        reset_a = 1'b1;
        tick();
        check("mid_rst_x", x_a, 0);
        check("mid_rst_y", y_a, 0);
        check("mid_rst_active", active_a, 1);
        check("mid_rst_blank", blank_a, 0);
        check("mid_rst_hs", hs_a, 1);
        check("mid_rst_vs", vs_a, 1);
        reset_a = 1'b0;
        tick();
        check("post_rst_blank", blank_a, 1);
        check("post_rst_x", x_a, 1);

        // Small raster, PIPE_DLY=3: two full frames plus two cycles against the model
        reset_b = 1'b0;
        #1;
        err_xy = 0; err_comb = 0; err_hs = 0; err_vs = 0; err_blank = 0;
        fs_cnt = 0; vs_win = 0; vb_frame = 0; max_x = 0; max_y = 0;
        for (int c = 0; c < 242; c++) begin
            int xm, ym;
            logic [2:0] dly;
            xm = c % 15;
            ym = (c / 15) % 8;
            dly = (c < 3) ? 3'b110 : small_raw(c - 3);
            if (int'(x_b) != xm || int'(y_b) != ym) err_xy++;
            if (active_b !== (xm < 8 && ym < 4) || vblank_b !== (ym >= 4) ||
                fs_b !== (xm == 0 && ym == 0) || sync_b !== 1'b0) err_comb++;
            if (hs_b !== dly[2]) err_hs++;
            if (vs_b !== dly[1]) err_vs++;
            if (blank_b !== dly[0]) err_blank++;
            if (fs_b) fs_cnt++;
            if (c >= 3 && c < 123 && !vs_b) vs_win++;
            if (c < 120 && vblank_b) vb_frame++;
            if (int'(x_b) > max_x) max_x = int'(x_b);
            if (int'(y_b) > max_y) max_y = int'(y_b);
            tick();
        end
        check("small_xy", err_xy, 0);
        check("small_comb", err_comb, 0);
        check("small_hs_lag3", err_hs, 0);
        check("small_vs_lag3", err_vs, 0);
        check("small_blank_lag3", err_blank, 0);
        check("small_fs_count", fs_cnt, 3);
        check("small_vs_low", vs_win, 30);
        check("small_vblank", vb_frame, 60);
        check("small_max_x", max_x, 14);
        check("small_max_y", max_y, 7);

        // Reset wins over ce; frame_start gated by ce
        reset_b = 1'b1; ce_b = 1'b1;
        tick();
        check("b_rst_wins_x", x_b, 0);
        check("b_rst_blank", blank_b, 0);
        reset_b = 1'b0; ce_b = 1'b0;
        #1;
        check("b_fs_ce0", fs_b, 0);
        tick();
        check("b_hold_x", x_b, 0);
        ce_b = 1'b1;
        #1;
        check("b_fs_ce1", fs_b, 1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
